// File: rtl/mem_responder_if.sv
// Word bus between the CPU control unit and mem_responder, plus the byte-wide RAM port.
// The master modport is the CPU/RAM side; the responder uses the slave modport.
interface mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              Req;
  logic              Wr;
  logic [31:0]       Address;
  logic [31:0]       Datain;
  logic [31:0]       Dataout;
  logic              Ready;
  logic              Busy;
  logic              AddrErr;
  logic [ADDR_W-1:0] RamAddr;
  logic              RamWr;
  logic [7:0]        RamDin;
  logic [7:0]        RamDout;

  modport master (
    output Req, Wr, Address, Datain, RamDout,
    input  Dataout, Ready, Busy, AddrErr, RamAddr, RamWr, RamDin
  );

  modport slave (
    input  Req, Wr, Address, Datain, RamDout,
    output Dataout, Ready, Busy, AddrErr, RamAddr, RamWr, RamDin
  );
endinterface

// File: rtl/mem_responder.sv
// Services one 32-bit big-endian read/write as four byte accesses to a synchronous
// byte-wide RAM, with WAIT extra cycles per byte and alignment/range rejection.
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 0
) (
  input  logic           Clk,
  input  logic           Reset,
  mem_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, RADDR, RCAP, WADDR, DONE} state_e;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       dout_q, dout_d;
  logic [1:0]        k_q, k_d;
  logic [3:0]        wait_q, wait_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr;
  logic [ADDR_W-1:0] byte_addr;
  logic [7:0]        wbyte;
  logic              bad_addr, wait_done;

  assign bad_addr  = (addr_q[1:0] != 2'b00) || ((addr_q >> ADDR_W) != 32'd0);
  assign wait_done = (wait_q == WAIT_LAST);
  assign byte_addr = addr_q[ADDR_W-1:0] + ADDR_W'(k_q);
  assign bus.Dataout = dout_q;
  assign bus.RamAddr = ram_addr;

  // Big-endian: byte k=0 carries the most significant byte.
  always_comb begin
    case (k_q)
      2'd0:    wbyte = din_q[31:24];
      2'd1:    wbyte = din_q[23:16];
      2'd2:    wbyte = din_q[15:8];
      default: wbyte = din_q[7:0];
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      asm_q      <= '0;
      dout_q     <= '0;
      k_q        <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      asm_q      <= asm_d;
      dout_q     <= dout_d;
      k_q        <= k_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      ram_addr_q <= ram_addr;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    din_d       = din_q;
    asm_d       = asm_q;
    dout_d      = dout_q;
    k_d         = k_q;
    wait_d      = wait_q;
    err_d       = err_q;
    ram_addr    = ram_addr_q;   // RAM address parks on its last value when idle
    bus.RamWr   = 1'b0;
    bus.RamDin  = 8'h00;
    bus.Ready   = 1'b0;
    bus.Busy    = 1'b0;
    bus.AddrErr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Req) begin
          wr_d    = bus.Wr;
          addr_d  = bus.Address;
          din_d   = bus.Datain;
          k_d     = '0;
          wait_d  = '0;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        bus.Busy = 1'b1;
        if (bad_addr) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = wr_q ? WADDR : RADDR;
        end
      end
      RADDR: begin
        bus.Busy = 1'b1;
        ram_addr = byte_addr;
        if (wait_done) begin
          wait_d  = '0;
          state_d = RCAP;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      RCAP: begin
        bus.Busy = 1'b1;
        ram_addr = byte_addr;
        asm_d    = {asm_q[23:0], bus.RamDout};
        if (k_q == 2'd3) begin
          dout_d  = {asm_q[23:0], bus.RamDout};
          state_d = DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = RADDR;
        end
      end
      WADDR: begin
        bus.Busy   = 1'b1;
        ram_addr   = byte_addr;
        bus.RamDin = wbyte;
        if (wait_done) begin
          bus.RamWr = 1'b1;
          wait_d    = '0;
          if (k_q == 2'd3) state_d = DONE;
          else             k_d     = k_q + 2'd1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      DONE: begin
        bus.Ready   = 1'b1;
        bus.AddrErr = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT=0, one with WAIT=3,
// each backed by a behavioural synchronous byte RAM.
module tb_mem_responder;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mem_responder_if #(.ADDR_W(8)) b0();
  mem_responder_if #(.ADDR_W(8)) b3();

  mem_responder #(.ADDR_W(8), .WAIT(0)) u0 (.Clk(Clk), .Reset(Reset), .bus(b0));
  mem_responder #(.ADDR_W(8), .WAIT(3)) u3 (.Clk(Clk), .Reset(Reset), .bus(b3));

  logic [7:0] ram0 [256];
  logic [7:0] ram3 [256];

  always @(posedge Clk) begin
    if (b0.RamWr) ram0[b0.RamAddr] <= b0.RamDin;
    b0.RamDout <= ram0[b0.RamAddr];
  end
  always @(posedge Clk) begin
    if (b3.RamWr) ram3[b3.RamAddr] <= b3.RamDin;
    b3.RamDout <= ram3[b3.RamAddr];
  end

  int rdy_cnt0 = 0;
  always @(negedge Clk) if (b0.Ready) rdy_cnt0 <= rdy_cnt0 + 1;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;
  logic [7:0] addr_log [$];

  logic        o_rdy, o_err, o_busy, o_wr;
  logic [31:0] o_dout;
  logic [7:0]  o_addr, o_din;
  assign o_rdy  = sel ? b3.Ready   : b0.Ready;
  assign o_err  = sel ? b3.AddrErr : b0.AddrErr;
  assign o_busy = sel ? b3.Busy    : b0.Busy;
  assign o_wr   = sel ? b3.RamWr   : b0.RamWr;
  assign o_dout = sel ? b3.Dataout : b0.Dataout;
  assign o_addr = sel ? b3.RamAddr : b0.RamAddr;
  assign o_din  = sel ? b3.RamDin  : b0.RamDin;

  task automatic drive(input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin b3.Req = req; b3.Wr = wr; b3.Address = a; b3.Datain = d; end
    else     begin b0.Req = req; b0.Wr = wr; b0.Address = a; b0.Datain = d; end
  endtask

  // Issues one request; lat is the cycle (edge 0 = accepting edge) in which Ready is seen.
  task automatic run_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int nwr);
    @(posedge Clk); #1 drive(1'b1, wr, a, d);
    @(posedge Clk); #1 drive(1'b0, wr, a, d);
    lat = 1; nwr = 0;
    addr_log.delete();
    while (lat < 100) begin
      @(negedge Clk);
      addr_log.push_back(o_addr);
      if (o_wr) nwr++;
      if (o_rdy) break;
      @(posedge Clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #2 Reset = 1'b0;
    #2;
    checks++; if (b0.Dataout !== 32'h0) begin errors++; $display("FAIL rst_dataout got %h want 0", b0.Dataout); end
    checks++; if (b0.Ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", b0.Ready); end
    checks++; if (b0.Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", b0.Busy); end
    checks++; if (b0.AddrErr !== 1'b0) begin errors++; $display("FAIL rst_addrerr got %b want 0", b0.AddrErr); end
    checks++; if (b0.RamAddr !== 8'h0) begin errors++; $display("FAIL rst_ramaddr got %h want 0", b0.RamAddr); end
    checks++; if (b0.RamWr !== 1'b0) begin errors++; $display("FAIL rst_ramwr got %b want 0", b0.RamWr); end
    checks++; if (b0.RamDin !== 8'h0) begin errors++; $display("FAIL rst_ramdin got %h want 0", b0.RamDin); end
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
  endtask

  task automatic test_write_read;
    int lat, nwr;
    sel = 1'b0;
    run_req(1'b1, 32'h10, 32'hDEADBEEF, lat, nwr);
    checks++; if (lat !== 6) begin errors++; $display("FAIL wr_latency got %0d want 6", lat); end
    checks++; if (nwr !== 4) begin errors++; $display("FAIL wr_ramwr_cycles got %0d want 4", nwr); end
    checks++; if (o_err !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL wr_done_flags got err=%b busy=%b want 0 0", o_err, o_busy); end
    @(posedge Clk); #1;
    checks++;
    if ({ram0[8'h10], ram0[8'h11], ram0[8'h12], ram0[8'h13]} !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_ram_bytes got %h %h %h %h want DE AD BE EF", ram0[8'h10], ram0[8'h11], ram0[8'h12], ram0[8'h13]);
    end
    run_req(1'b0, 32'h10, 32'h0, lat, nwr);
    checks++; if (lat !== 10) begin errors++; $display("FAIL rd_latency got %0d want 10", lat); end
    checks++; if (o_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", o_dout); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL rd_ramwr got %0d want 0", nwr); end
    @(negedge Clk);
    checks++; if (o_rdy !== 1'b0 || o_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got rdy=%b data=%h want 0 deadbeef", o_rdy, o_dout); end
  endtask

  task automatic test_errors;
    int lat, nwr;
    sel = 1'b0;
    run_req(1'b0, 32'h11, 32'h0, lat, nwr);
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_latency got %0d want 2", lat); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL mis_addrerr got %b want 1", o_err); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL mis_ramwr got %0d want 0", nwr); end
    checks++; if (o_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_dataout got %h want deadbeef", o_dout); end
    @(negedge Clk);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL mis_err_pulse got %b want 0", o_err); end
    run_req(1'b0, 32'h100, 32'h0, lat, nwr);
    checks++; if (lat !== 2 || o_err !== 1'b1) begin errors++; $display("FAIL range_err got lat=%0d err=%b want 2 1", lat, o_err); end
    checks++; if (o_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL range_dataout got %h want deadbeef", o_dout); end
    run_req(1'b1, 32'h12, 32'h01020304, lat, nwr);
    checks++; if (lat !== 2 || o_err !== 1'b1 || nwr !== 0) begin errors++; $display("FAIL miswr got lat=%0d err=%b nwr=%0d want 2 1 0", lat, o_err, nwr); end
    @(posedge Clk); #1;
    checks++;
    if ({ram0[8'h10], ram0[8'h11], ram0[8'h12], ram0[8'h13]} !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL miswr_ram got %h%h%h%h want deadbeef", ram0[8'h10], ram0[8'h11], ram0[8'h12], ram0[8'h13]);
    end
  endtask

  task automatic test_wait3;
    int lat, nwr, bad;
    sel = 1'b1;
    run_req(1'b1, 32'hFC, 32'h0000002A, lat, nwr);
    checks++; if (lat !== 18 || nwr !== 4) begin errors++; $display("FAIL w3_write got lat=%0d nwr=%0d want 18 4", lat, nwr); end
    run_req(1'b0, 32'hFC, 32'h0, lat, nwr);
    checks++; if (lat !== 22) begin errors++; $display("FAIL w3_rd_latency got %0d want 22", lat); end
    checks++; if (o_dout !== 32'h0000002A) begin errors++; $display("FAIL w3_rd_data got %h want 0000002a", o_dout); end
    bad = 0;
    for (int i = 1; i <= 20; i++)
      if (i >= addr_log.size() || addr_log[i] !== 8'(8'hFC + (i - 1) / 5)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL w3_ramaddr_hold got %0d wrong cycles want 0", bad); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc, n, c0;
    int rc [3];
    logic [31:0] dv [3];
    sel = 1'b0; n = 0;
    @(posedge Clk); #1 c0 = rdy_cnt0; drive(1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
    @(posedge Clk); cyc = 1;
    while (n < 3 && cyc < 80) begin
      @(negedge Clk);
      if (cyc == 3) drive(1'b1, 1'b1, 32'h80, 32'h0BADBAD0);   // changes while busy must be ignored
      if (o_rdy) begin
        rc[n] = cyc; dv[n] = o_dout; n++;
        if (n == 1)      drive(1'b1, 1'b0, 32'h40, 32'h0);
        else if (n == 2) drive(1'b1, 1'b0, 32'h10, 32'h0);
        else             drive(1'b0, 1'b0, 32'h0, 32'h0);
      end
      @(posedge Clk); cyc++;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n); end
    if (n == 3) begin
      checks++; if (rc[0] !== 6 || rc[1] !== 17 || rc[2] !== 28) begin errors++; $display("FAIL b2b_ready_cycles got %0d %0d %0d want 6 17 28", rc[0], rc[1], rc[2]); end
      checks++; if (dv[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_read1 got %h want cafef00d", dv[1]); end
      checks++; if (dv[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_read2 got %h want deadbeef", dv[2]); end
    end
    repeat (5) @(posedge Clk);
    #1;
    checks++; if (rdy_cnt0 - c0 !== 3 || o_busy !== 1'b0) begin errors++; $display("FAIL b2b_accepts got %0d busy=%b want 3 0", rdy_cnt0 - c0, o_busy); end
  endtask

  task automatic test_reset_midwrite;
    int lat, nwr, c0;
    sel = 1'b0;
    run_req(1'b1, 32'h20, 32'h55555555, lat, nwr);
    @(posedge Clk); #1 c0 = rdy_cnt0;
    drive(1'b1, 1'b1, 32'h20, 32'h11223344);
    @(posedge Clk); #1 drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++; if (o_wr !== 1'b1 || o_addr !== 8'h22 || o_din !== 8'h33) begin errors++; $display("FAIL mid_byte2 got wr=%b addr=%h din=%h want 1 22 33", o_wr, o_addr, o_din); end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_wr !== 1'b0 || o_addr !== 8'h0 || o_din !== 8'h0 || o_rdy !== 1'b0 || o_dout !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outs got busy=%b wr=%b addr=%h din=%h rdy=%b dout=%h want all 0", o_busy, o_wr, o_addr, o_din, o_rdy, o_dout);
    end
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    checks++; if (rdy_cnt0 !== c0) begin errors++; $display("FAIL mid_no_ready got %0d pulses want 0", rdy_cnt0 - c0); end
    checks++;
    if ({ram0[8'h20], ram0[8'h21], ram0[8'h22], ram0[8'h23]} !== 32'h11225555) begin
      errors++;
      $display("FAIL mid_ram got %h%h%h%h want 11225555", ram0[8'h20], ram0[8'h21], ram0[8'h22], ram0[8'h23]);
    end
  endtask

  initial begin
    sel = 1'b0; drive(1'b0, 1'b0, 32'h0, 32'h0);
    sel = 1'b1; drive(1'b0, 1'b0, 32'h0, 32'h0);
    sel = 1'b0;
    test_reset();
    test_write_read();
    test_errors();
    test_wait3();
    test_back_to_back();
    test_reset_midwrite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
